enc_sym_pack: RTL

- JPEG entropy-encode page. It is the transmit-side counterpart of the DecSym symbol decoder.
- Consumes 16-bit symbol tokens {run, size, amplitude}.
- Looks up each Huffman code through an external code-table stream pair (ftabind out, ftabval in).
- Packs code bits and amplitude bits MSB-first into 16-bit words for the downstream bitstream writer.
- All streams use the codebase d/e/v/b protocol: transfer occurs when v=1 and b=0 in the same cycle; e=1 with v=1 marks end-of-stream (d ignored).

---
 rtl/enc_sym_pack.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/enc_sym_pack.sv
// rtl/enc_sym_pack.sv - JPEG symbol Huffman packer; ENC_SYM_PAD_ONES_EN selects ones fill on flush
module enc_sym_pack #(
  parameter int ACC_W    = 32,
  parameter int MAX_SIZE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] symToken_d,
  input  logic        symToken_e,
  input  logic        symToken_v,
  output logic        symToken_b,
  output logic [7:0]  ftabind_d,
  output logic        ftabind_e,
  output logic        ftabind_v,
  input  logic        ftabind_b,
  input  logic [15:0] ftabval_d,
  input  logic        ftabval_e,
  input  logic        ftabval_v,
  output logic        ftabval_b,
  output logic [15:0] bitsOut_d,
  output logic        bitsOut_e,
  output logic        bitsOut_v,
  input  logic        bitsOut_b
);

  localparam int         CW     = $clog2(ACC_W + 1);
  localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CODE, S_AMP, S_FLUSH, S_EOS
  } state_t;

  state_t state, next_state;

  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [3:0]       run, size, code_len;
  logic [7:0]       amp;
  logic [11:0]      code;

  logic             full;
  logic [15:0]      top, pad_fill;
  logic [3:0]       tok_size, val_len;
  logic             sym_b, ind_v, val_b, out_v, out_e;
  logic [15:0]      out_d;
  logic             accept, emit, flush_word, clear_all, append_en;
  logic [ACC_W-1:0] app_bits;
  logic [3:0]       app_len;
  logic [CW-1:0]    shamt;
  logic             unused_ok;

  assign unused_ok = ftabval_e;

  // acc holds the pending bits left-aligned; the oldest bit is always acc[ACC_W-1]
  assign full     = (cnt >= CW'(16));
  assign top      = acc[ACC_W-1 -: 16];
  assign tok_size = (symToken_d[11:8] > MAX_SZ) ? MAX_SZ : symToken_d[11:8];
  assign val_len  = (ftabval_d[15:12] > 4'd12) ? 4'd12 : ftabval_d[15:12];
  assign shamt    = CW'(ACC_W) - cnt - CW'(app_len);

`ifdef ENC_SYM_PAD_ONES_EN
  assign pad_fill = 16'hFFFF >> cnt[3:0];
`else
  assign pad_fill = 16'h0000;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode, handshake strobes and append selection
  always_comb begin
    next_state = state;
    sym_b      = 1'b1;
    ind_v      = 1'b0;
    val_b      = 1'b1;
    out_v      = full;
    out_e      = 1'b0;
    out_d      = top;
    accept     = 1'b0;
    flush_word = 1'b0;
    clear_all  = 1'b0;
    append_en  = 1'b0;
    app_bits   = '0;
    app_len    = 4'd0;
    case (state)
      S_IDLE: begin
        sym_b = full;
        if (symToken_v && !full) begin
          accept     = 1'b1;
          next_state = symToken_e ? S_FLUSH : S_REQ;
        end
      end
      S_REQ: begin
        ind_v = 1'b1;
        if (!ftabind_b) next_state = S_WAIT;
      end
      S_WAIT: begin
        val_b = 1'b0;
        if (ftabval_v) next_state = S_CODE;
      end
      S_CODE: begin
        if (!full) begin
          append_en  = 1'b1;
          app_len    = code_len;
          app_bits   = ACC_W'(code & ~(12'hFFF << code_len));
          next_state = S_AMP;
        end
      end
      S_AMP: begin
        if (!full) begin
          append_en  = 1'b1;
          app_len    = size;
          app_bits   = ACC_W'(amp & ~(8'hFF << size));
          next_state = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          next_state = S_EOS;
        end else if (!full) begin
          out_v = 1'b1;
          out_d = top | pad_fill;
          if (!bitsOut_b) begin
            flush_word = 1'b1;
            next_state = S_EOS;
          end
        end
      end
      S_EOS: begin
        out_v = 1'b1;
        out_e = 1'b1;
        out_d = 16'h0000;
        if (!bitsOut_b) begin
          clear_all  = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Full words leave whenever the writer is ready, independent of state
  assign emit = full && !bitsOut_b;

  // Bit accumulator plus latched token and table response fields
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      run      <= 4'd0;
      size     <= 4'd0;
      amp      <= 8'd0;
      code_len <= 4'd0;
      code     <= 12'd0;
    end else begin
      if (clear_all || flush_word) begin
        acc <= '0;
        cnt <= '0;
      end else if (emit) begin
        acc <= acc << 16;
        cnt <= cnt - CW'(16);
      end else if (append_en) begin
        acc <= acc | (app_bits << shamt);
        cnt <= cnt + CW'(app_len);
      end
      if (accept && !symToken_e) begin
        run  <= symToken_d[15:12];
        size <= tok_size;
        amp  <= symToken_d[7:0];
      end
      if (state == S_WAIT && ftabval_v) begin
        code_len <= val_len;
        code     <= ftabval_d[11:0];
      end
    end
  end

  assign symToken_b = reset | sym_b;
  assign ftabind_v  = ~reset & ind_v;
  assign ftabind_d  = (reset || !ind_v) ? 8'h00 : {run, size};
  assign ftabind_e  = 1'b0;
  assign ftabval_b  = reset | val_b;
  assign bitsOut_v  = ~reset & out_v;
  assign bitsOut_e  = ~reset & out_e;
  assign bitsOut_d  = reset ? 16'h0000 : out_d;

endmodule
